match_ctrl: RTL and testbench



---
 rtl/match_ctrl_if.sv | 32 +++
 rtl/match_ctrl.sv | 159 +++++++++++++++
 tb/tb_match_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/match_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : match_ctrl_if
// Description : Bundle between the match controller and its neighbours:
//               keyboard/physics inputs in, ball control and HUD data out.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_ctrl_if;
  logic [7:0] keycode;
  logic       point_l;
  logic       point_r;
  logic       ball_hold;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;
  logic [2:0] state;
  logic [6:0] serve_cnt;

  // Driver side: keyboard decoder and ball physics
  modport master (
    output keycode, point_l, point_r,
    input  ball_hold, serve_dir, score_l, score_r, winner, state, serve_cnt
  );

  // Controller side
  modport slave (
    input  keycode, point_l, point_r,
    output ball_hold, serve_dir, score_l, score_r, winner, state, serve_cnt
  );
endinterface
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : match_ctrl
// Description : Per-frame match controller. Runs the serve countdown, keeps
//               the scores, handles pause and declares the winner.
//               Optional macro DEUCE_EN: win needs a two-point lead (a
//               player reaching 15 wins outright).
// Revision    : 1.0 - initial release
// ============================================================================
module match_ctrl #(
  parameter int         WIN_SCORE   = 7,
  parameter int         SERVE_DELAY = 60,
  parameter logic [7:0] START_KEY   = 8'h2C,
  parameter logic [7:0] PAUSE_KEY   = 8'h13
) (
  input  logic         frame_clk,
  input  logic         Reset,
  match_ctrl_if.slave  bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SERVE = 3'd1;
  localparam logic [2:0] c_PLAY  = 3'd2;
  localparam logic [2:0] c_PAUSE = 3'd3;
  localparam logic [2:0] c_OVER  = 3'd4;

  localparam logic [6:0] c_RELOAD = 7'(SERVE_DELAY - 1);
  localparam logic [3:0] c_WIN    = 4'(WIN_SCORE);

  logic [2:0] r_state,   w_state;
  logic       r_hold,    w_hold;
  logic       r_dir,     w_dir;
  logic [3:0] r_score_l, w_score_l;
  logic [3:0] r_score_r, w_score_r;
  logic [1:0] r_winner,  w_winner;
  logic [6:0] r_cnt,     w_cnt;
  logic [7:0] r_key_prev;

  logic       w_start_evt;
  logic       w_pause_evt;
  logic [3:0] w_inc_l;
  logic [3:0] w_inc_r;
  logic       w_l_wins;
  logic       w_r_wins;

  // A held key produces a single event on its first frame only
  assign w_start_evt = (bus.keycode == START_KEY) && (r_key_prev != START_KEY);
  assign w_pause_evt = (bus.keycode == PAUSE_KEY) && (r_key_prev != PAUSE_KEY);

  // Saturating increments: scores stick at 15
  assign w_inc_l = (r_score_l == 4'hF) ? 4'hF : r_score_l + 4'd1;
  assign w_inc_r = (r_score_r == 4'hF) ? 4'hF : r_score_r + 4'd1;

`ifdef DEUCE_EN
  assign w_l_wins = (w_inc_l == 4'hF) ||
                    ((w_inc_l >= c_WIN) && ({1'b0, w_inc_l} >= {1'b0, r_score_r} + 5'd2));
  assign w_r_wins = (w_inc_r == 4'hF) ||
                    ((w_inc_r >= c_WIN) && ({1'b0, w_inc_r} >= {1'b0, r_score_l} + 5'd2));
`else
  assign w_l_wins = (w_inc_l >= c_WIN);
  assign w_r_wins = (w_inc_r >= c_WIN);
`endif

  // Next-frame match state, scores and serve countdown
  always_comb begin
    w_state   = r_state;
    w_dir     = r_dir;
    w_score_l = r_score_l;
    w_score_r = r_score_r;
    w_winner  = r_winner;
    w_cnt     = r_cnt;
    case (r_state)
      c_IDLE, c_OVER: begin
        if (w_start_evt) begin
          w_state   = c_SERVE;
          w_score_l = 4'd0;
          w_score_r = 4'd0;
          w_winner  = 2'b00;
          w_cnt     = c_RELOAD;
        end
      end
      c_SERVE: begin
        if (r_cnt == 7'd0) begin
          w_state = c_PLAY;
        end else begin
          w_cnt = r_cnt - 7'd1;
        end
      end
      c_PLAY: begin
        // A point outranks a pause press; simultaneous points cancel out
        if (bus.point_l && !bus.point_r) begin
          w_score_l = w_inc_l;
          w_dir     = 1'b1;
          if (w_l_wins) begin
            w_state  = c_OVER;
            w_winner = 2'b01;
          end else begin
            w_state = c_SERVE;
            w_cnt   = c_RELOAD;
          end
        end else if (bus.point_r && !bus.point_l) begin
          w_score_r = w_inc_r;
          w_dir     = 1'b0;
          if (w_r_wins) begin
            w_state  = c_OVER;
            w_winner = 2'b10;
          end else begin
            w_state = c_SERVE;
            w_cnt   = c_RELOAD;
          end
        end else if (w_pause_evt) begin
          w_state = c_PAUSE;
        end
      end
      c_PAUSE: begin
        if (w_pause_evt) begin
          w_state = c_PLAY;
        end
      end
      default: begin
        w_state = c_IDLE;
      end
    endcase
    w_hold = (w_state != c_PLAY);
  end

  // Frame register bank with asynchronous reset
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= c_IDLE;
      r_hold     <= 1'b1;
      r_dir      <= 1'b1;
      r_score_l  <= 4'd0;
      r_score_r  <= 4'd0;
      r_winner   <= 2'b00;
      r_cnt      <= 7'd0;
      r_key_prev <= 8'd0;
    end else begin
      r_state    <= w_state;
      r_hold     <= w_hold;
      r_dir      <= w_dir;
      r_score_l  <= w_score_l;
      r_score_r  <= w_score_r;
      r_winner   <= w_winner;
      r_cnt      <= w_cnt;
      r_key_prev <= bus.keycode;
    end
  end

  assign bus.state     = r_state;
  assign bus.ball_hold = r_hold;
  assign bus.serve_dir = r_dir;
  assign bus.score_l   = r_score_l;
  assign bus.score_r   = r_score_r;
  assign bus.winner    = r_winner;
  assign bus.serve_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_ctrl
// Description : Self-checking bench for match_ctrl: directed vector table,
//               hand-written win/deuce/reset sequences, and a randomized run
//               against a behavioural match model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_ctrl;

  localparam logic [7:0] K_START = 8'h2C;
  localparam logic [7:0] K_PAUSE = 8'h13;
  localparam int         SD      = 60;
  localparam int         WIN     = 7;

  logic frame_clk = 1'b0;
  logic Reset;

  always #5 frame_clk = ~frame_clk;

  match_ctrl_if bus ();

  match_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [7:0] key;
    logic       pl;
    logic       pr;
    int         frames;
    logic [2:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       dir;
    logic       hold;
    logic [1:0] win;
    logic [6:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic [7:0] key, logic pl, logic pr, int frames,
                              logic [2:0] st, logic [3:0] sl, logic [3:0] sr, logic dir,
                              logic hold, logic [1:0] win, logic [6:0] cnt);
    vec_t v;
    v.name = name; v.key = key; v.pl = pl; v.pr = pr; v.frames = frames;
    v.st = st; v.sl = sl; v.sr = sr; v.dir = dir; v.hold = hold; v.win = win; v.cnt = cnt;
    return v;
  endfunction

  // Apply inputs for one frame, then sample just after the edge
  task automatic frame(input logic [7:0] k, input logic pl, input logic pr);
    bus.keycode = k;
    bus.point_l = pl;
    bus.point_r = pr;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [3:0] sl,
                       input logic [3:0] sr, input logic dir, input logic hold,
                       input logic [1:0] win, input logic [6:0] cnt);
    n_cmp++;
    if ({bus.state, bus.score_l, bus.score_r, bus.serve_dir, bus.ball_hold, bus.winner, bus.serve_cnt}
        !== {st, sl, sr, dir, hold, win, cnt}) begin
      n_bad++;
      $display("FAIL %s: got st=%0d sl=%0d sr=%0d dir=%0b hold=%0b win=%0d cnt=%0d, want st=%0d sl=%0d sr=%0d dir=%0b hold=%0b win=%0d cnt=%0d",
               name, bus.state, bus.score_l, bus.score_r, bus.serve_dir, bus.ball_hold,
               bus.winner, bus.serve_cnt, st, sl, sr, dir, hold, win, cnt);
    end
  endtask

  // ---------------- behavioural match model ----------------
  int         m_state, m_sl, m_sr, m_dir, m_win, m_cnt;
  logic [7:0] m_prev;

  task automatic m_reset();
    m_state = 0; m_sl = 0; m_sr = 0; m_dir = 1; m_win = 0; m_cnt = 0; m_prev = 8'h00;
  endtask

  function automatic bit m_wins(int s, int o);
`ifdef DEUCE_EN
    return (s == 15) || (s >= WIN && s - o >= 2);
`else
    return s >= WIN;
`endif
  endfunction

  task automatic m_step(input logic [7:0] k, input logic pl, input logic pr);
    bit s_ev;
    bit p_ev;
    s_ev = (k == K_START) && (m_prev != K_START);
    p_ev = (k == K_PAUSE) && (m_prev != K_PAUSE);
    case (m_state)
      0, 4: if (s_ev) begin
        m_state = 1; m_sl = 0; m_sr = 0; m_win = 0; m_cnt = SD - 1;
      end
      1: if (m_cnt == 0) m_state = 2; else m_cnt = m_cnt - 1;
      2: begin
        if (pl && !pr) begin
          m_sl = (m_sl < 15) ? m_sl + 1 : 15;
          m_dir = 1;
          if (m_wins(m_sl, m_sr)) begin m_state = 4; m_win = 1; end
          else begin m_state = 1; m_cnt = SD - 1; end
        end else if (pr && !pl) begin
          m_sr = (m_sr < 15) ? m_sr + 1 : 15;
          m_dir = 0;
          if (m_wins(m_sr, m_sl)) begin m_state = 4; m_win = 2; end
          else begin m_state = 1; m_cnt = SD - 1; end
        end else if (p_ev) begin
          m_state = 3;
        end
      end
      3: if (p_ev) m_state = 2;
      default: m_state = 0;
    endcase
    m_prev = k;
  endtask

  initial begin
    logic [7:0] keys[4];
    logic [7:0] k;
    logic       pl, pr;

    keys[0] = 8'h00; keys[1] = K_START; keys[2] = K_PAUSE; keys[3] = 8'h1C;

    Reset       = 1'b1;
    bus.keycode = 8'h00;
    bus.point_l = 1'b0;
    bus.point_r = 1'b0;
    #2;
    check("reset", 3'd0, 4'd0, 4'd0, 1'b1, 1'b1, 2'b00, 7'd0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    // ---------------- directed vector table ----------------
    tbl.push_back(mk("start",        K_START, 0, 0, 1,  3'd1, 4'd1-4'd1, 4'd0, 1, 1, 2'b00, 7'd59));
    tbl.push_back(mk("serve_cnt",    8'h00,   0, 0, 59, 3'd1, 4'd0, 4'd0, 1, 1, 2'b00, 7'd0));
    tbl.push_back(mk("serve_end",    8'h00,   0, 0, 1,  3'd2, 4'd0, 4'd0, 1, 0, 2'b00, 7'd0));
    tbl.push_back(mk("pt_l",         8'h00,   1, 0, 1,  3'd1, 4'd1, 4'd0, 1, 1, 2'b00, 7'd59));
    tbl.push_back(mk("serve2",       8'h00,   0, 0, 60, 3'd2, 4'd1, 4'd0, 1, 0, 2'b00, 7'd0));
    tbl.push_back(mk("pt_r",         8'h00,   0, 1, 1,  3'd1, 4'd1, 4'd1, 0, 1, 2'b00, 7'd59));
    tbl.push_back(mk("serve3",       8'h00,   0, 0, 60, 3'd2, 4'd1, 4'd1, 0, 0, 2'b00, 7'd0));
    tbl.push_back(mk("both_pts",     8'h00,   1, 1, 1,  3'd2, 4'd1, 4'd1, 0, 0, 2'b00, 7'd0));
    tbl.push_back(mk("pause_hold",   K_PAUSE, 0, 0, 10, 3'd3, 4'd1, 4'd1, 0, 1, 2'b00, 7'd0));
    tbl.push_back(mk("pause_pt",     K_PAUSE, 1, 0, 1,  3'd3, 4'd1, 4'd1, 0, 1, 2'b00, 7'd0));
    tbl.push_back(mk("pause_start",  K_START, 0, 0, 1,  3'd3, 4'd1, 4'd1, 0, 1, 2'b00, 7'd0));
    tbl.push_back(mk("pause_rel",    8'h00,   0, 0, 1,  3'd3, 4'd1, 4'd1, 0, 1, 2'b00, 7'd0));
    tbl.push_back(mk("resume",       K_PAUSE, 0, 0, 1,  3'd2, 4'd1, 4'd1, 0, 0, 2'b00, 7'd0));
    tbl.push_back(mk("rel2",         8'h00,   0, 0, 1,  3'd2, 4'd1, 4'd1, 0, 0, 2'b00, 7'd0));
    tbl.push_back(mk("pt_over_pause",K_PAUSE, 1, 0, 1,  3'd1, 4'd2, 4'd1, 1, 1, 2'b00, 7'd59));
    tbl.push_back(mk("serve4",       8'h00,   0, 0, 60, 3'd2, 4'd2, 4'd1, 1, 0, 2'b00, 7'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      for (int f = 0; f < tbl[i].frames; f++) frame(tbl[i].key, tbl[i].pl, tbl[i].pr);
      check(tbl[i].name, tbl[i].st, tbl[i].sl, tbl[i].sr, tbl[i].dir, tbl[i].hold,
            tbl[i].win, tbl[i].cnt);
    end

    // ---------------- left player runs out to the win ----------------
    for (int i = 1; i <= 5; i++) begin
      frame(8'h00, 1'b1, 1'b0);
      if (i < 5) begin
        check("win_run", 3'd1, 4'(2 + i), 4'd1, 1, 1, 2'b00, 7'd59);
        idle(SD);
      end else begin
        check("win_over", 3'd4, 4'd7, 4'd1, 1, 1, 2'b01, 7'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      frame(8'h00, 1'b0, 1'b1);
      frame(8'h00, 1'b1, 1'b0);
      check("over_frozen", 3'd4, 4'd7, 4'd1, 1, 1, 2'b01, 7'd0);
    end
    frame(K_START, 1'b0, 1'b0);
    check("restart", 3'd1, 4'd0, 4'd0, 1, 1, 2'b00, 7'd59);
    idle(SD);
    check("restart_play", 3'd2, 4'd0, 4'd0, 1, 0, 2'b00, 7'd0);

    // ---------------- 6-6 then left scores (deuce boundary) ----------------
    for (int i = 0; i < 6; i++) begin
      frame(8'h00, 1'b1, 1'b0); idle(SD);
      frame(8'h00, 1'b0, 1'b1); idle(SD);
    end
    check("six_all", 3'd2, 4'd6, 4'd6, 0, 0, 2'b00, 7'd0);
    frame(8'h00, 1'b1, 1'b0);
`ifdef DEUCE_EN
    check("deuce_7_6", 3'd1, 4'd7, 4'd6, 1, 1, 2'b00, 7'd59);
    idle(SD);
    frame(8'h00, 1'b1, 1'b0);
    check("deuce_8_6", 3'd4, 4'd8, 4'd6, 1, 1, 2'b01, 7'd0);
`else
    check("win_7_6", 3'd4, 4'd7, 4'd6, 1, 1, 2'b01, 7'd0);
`endif

    // ---------------- asynchronous reset mid-countdown ----------------
    frame(K_START, 1'b0, 1'b0);
    idle(20);
    check("pre_reset", 3'd1, 4'd0, 4'd0, 1, 1, 2'b00, 7'd39);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset", 3'd0, 4'd0, 4'd0, 1, 1, 2'b00, 7'd0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    // ---------------- randomized run against the model ----------------
    m_reset();
    k = 8'h00;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 9) < 3) k = keys[$urandom_range(0, 3)];
      pl = ($urandom_range(0, 19) == 0);
      pr = ($urandom_range(0, 19) == 0);
      m_step(k, pl, pr);
      frame(k, pl, pr);
      check($sformatf("rand[%0d]", n), 3'(m_state), 4'(m_sl), 4'(m_sr), m_dir[0],
            (m_state != 2), 2'(m_win), 7'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
